// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: operand width, register count and
// register-address types used by the register file, ALU and datapath.
package mips_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 8;
    localparam int REG_AW = $clog2(NREGS);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_AW-1:0] regaddr_t;

    localparam regaddr_t REG_ZERO = {REG_AW{1'b0}};

endpackage

// File: rtl/mips_reg_cell.sv
// Single architectural register: synchronous active-high reset clears it,
// otherwise it loads d when its decoded write enable is set.
module mips_reg_cell #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Storage with reset taking priority over the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= {WIDTH{1'b0}};
        end else if (we) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/mips_regfile.sv
// Register file feeding both ALU operands: r0 hardwired to zero, synchronous
// writes, combinational reads with optional write-to-read forwarding.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int   WIDTH  = mips_pkg::DATA_W,
    parameter int   NREGS  = mips_pkg::NREGS,
    localparam int  AW     = $clog2(NREGS),
    parameter bit   BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    logic [WIDTH-1:0] regs_s [NREGS];
    logic [NREGS-1:0] wen_s;
    logic             fwd_en_s;
    logic [WIDTH-1:0] rd1_s;
    logic [WIDTH-1:0] rd2_s;
    logic [WIDTH-1:0] dbg_s;

    // Entry 0 has no storage; every read of it sees zero.
    assign regs_s[0] = {WIDTH{1'b0}};
    assign wen_s[0]  = 1'b0;

    // One-hot write decode for the stored entries; wa==0 selects nothing.
    always_comb begin
        wen_s[NREGS-1:1] = {(NREGS-1){1'b0}};
        for (int i = 1; i < NREGS; i++) begin
            if (we && (wa == AW'(i))) begin
                wen_s[i] = 1'b1;
            end else begin
                wen_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 1; g < NREGS; g++) begin : g_cell
        mips_reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .rst (rst),
            .we  (wen_s[g]),
            .d   (wd),
            .q   (regs_s[g])
        );
    end

    // Forwarding is suppressed in the reset cycle since the write is dropped.
    assign fwd_en_s = BYPASS && we && !rst && (wa != REG_ZERO);

    // Read port 1 (ALU operand a).
    always_comb begin
        rd1_s = regs_s[ra1];
        if (fwd_en_s && (wa == ra1)) begin
            rd1_s = wd;
        end else begin
            rd1_s = regs_s[ra1];
        end
    end

    // Read port 2 (ALU operand b).
    always_comb begin
        rd2_s = regs_s[ra2];
        if (fwd_en_s && (wa == ra2)) begin
            rd2_s = wd;
        end else begin
            rd2_s = regs_s[ra2];
        end
    end

    // Debug observation port, same read rules as the operand ports.
    always_comb begin
        dbg_s = regs_s[dbg_addr];
        if (fwd_en_s && (wa == dbg_addr)) begin
            dbg_s = wd;
        end else begin
            dbg_s = regs_s[dbg_addr];
        end
    end

    assign rd1      = rd1_s;
    assign rd2      = rd2_s;
    assign dbg_data = dbg_s;

endmodule

// File: tb/tb_mips_regfile.sv
// Directed plus random bench for mips_regfile, covering both forwarding
// modes side by side with a queue-based scoreboard.
module tb_mips_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic [2:0] ra1, ra2, wa, dbg_addr;
    logic [7:0] wd;
    logic [7:0] rd1_0, rd2_0, dbg_0;
    logic [7:0] rd1_1, rd2_1, dbg_1;

    logic [7:0] model [8];
    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] exp;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    mips_regfile #(.BYPASS(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_0), .rd2(rd2_0),
        .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_0)
    );

    mips_regfile #(.BYPASS(1'b1)) u_dut_b (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_1), .rd2(rd2_1),
        .we(we), .wa(wa), .wd(wd), .dbg_addr(dbg_addr), .dbg_data(dbg_1)
    );

    function automatic logic [7:0] mread(input logic [2:0] a, input bit byp);
        if (byp && we && !rst && (wa != 3'd0) && (wa == a)) return wd;
        return (a == 3'd0) ? 8'h00 : model[a];
    endfunction

    function automatic void push(input string tag, input int sel, input logic [7:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb_q.push_back(x);
    endfunction

    function automatic void push_model(input string tag);
        push({tag, "_rd1_nb"}, 0, mread(ra1, 1'b0));
        push({tag, "_rd2_nb"}, 1, mread(ra2, 1'b0));
        push({tag, "_dbg_nb"}, 2, mread(dbg_addr, 1'b0));
        push({tag, "_rd1_b"},  3, mread(ra1, 1'b1));
        push({tag, "_rd2_b"},  4, mread(ra2, 1'b1));
        push({tag, "_dbg_b"},  5, mread(dbg_addr, 1'b1));
    endfunction

    function automatic logic [7:0] observe(input int sel);
        case (sel)
            0:       return rd1_0;
            1:       return rd2_0;
            2:       return dbg_0;
            3:       return rd1_1;
            4:       return rd2_1;
            5:       return dbg_1;
            6:       return {7'd0, (rd1_0 == 8'h00)};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic drain();
        exp_t       e;
        logic [7:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.sel);
            n_assert++;
            assert (o === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%02h expected=%02h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic setin(input logic r, input logic w, input logic [2:0] a,
                         input logic [7:0] d, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [2:0] ad);
        rst = r; we = w; wa = a; wd = d; ra1 = a1; ra2 = a2; dbg_addr = ad;
        #1;
    endtask

    task automatic tick();
        logic       r, w;
        logic [2:0] a;
        logic [7:0] d;
        r = rst; w = we; a = wa; d = wd;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 8; i++) model[i] = 8'h00;
        end else if (w && (a != 3'd0)) begin
            model[a] = d;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        setin(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0);
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0);

        // Reset sweep: every address reads zero on every port.
        for (int i = 0; i < 8; i++) begin
            setin(1'b0, 1'b0, 3'd0, 8'h00, 3'(i), 3'(7 - i), 3'(i));
            push("rst_rd1", 0, 8'h00);
            push("rst_rd2", 1, 8'h00);
            push("rst_dbg", 5, 8'h00);
            push_model("rst_sweep");
            drain();
        end

        // Write/readback.
        setin(1'b0, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 3'd0); tick();
        setin(1'b0, 1'b1, 3'd7, 8'h3C, 3'd0, 3'd0, 3'd0); tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 3'd3);
        push("wr_rd1_r3", 0, 8'hA5);
        push("wr_rd2_r7", 1, 8'h3C);
        push("wr_dbg_r3", 2, 8'hA5);
        push("wr_rd1_r3_b", 3, 8'hA5);
        push_model("wr");
        drain();

        // r0 is immutable, including the forwarding path.
        setin(1'b0, 1'b1, 3'd0, 8'hFF, 3'd0, 3'd0, 3'd0);
        push("r0_same_nb", 0, 8'h00);
        push("r0_same_b", 3, 8'h00);
        drain();
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 3'd0);
        push("r0_after_nb", 0, 8'h00);
        push("r0_after_b", 3, 8'h00);
        drain();

        // Same-cycle read/write of r5.
        setin(1'b0, 1'b1, 3'd5, 8'h11, 3'd0, 3'd0, 3'd0); tick();
        setin(1'b0, 1'b1, 3'd5, 8'h22, 3'd5, 3'd5, 3'd5);
        push("rw_before_nb", 0, 8'h11);
        push("rw_before_b", 3, 8'h22);
        push("rw_dbg_b", 5, 8'h22);
        push_model("rw_before");
        drain();
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd5, 3'd5, 3'd5);
        push("rw_after_nb", 0, 8'h22);
        push("rw_after_b", 3, 8'h22);
        drain();

        // Reset wins over a simultaneous write; no forwarding in that cycle.
        setin(1'b0, 1'b1, 3'd2, 8'h55, 3'd0, 3'd0, 3'd0); tick();
        setin(1'b1, 1'b1, 3'd2, 8'h77, 3'd2, 3'd2, 3'd2);
        push("rstcyc_nb", 0, 8'h55);
        push("rstcyc_b", 3, 8'h55);
        push_model("rstcyc");
        drain();
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd5, 3'd3);
        push("rstpri_nb", 0, 8'h00);
        push("rstpri_b", 3, 8'h00);
        push("rst_r5", 1, 8'h00);
        push("rst_r3_dbg", 2, 8'h00);
        drain();

        // ALU loop: r4 = r1 + r2, then r6 = r1 - r1.
        setin(1'b0, 1'b1, 3'd1, 8'h05, 3'd0, 3'd0, 3'd0); tick();
        setin(1'b0, 1'b1, 3'd2, 8'h03, 3'd0, 3'd0, 3'd0); tick();
        setin(1'b0, 1'b0, 3'd4, 8'h00, 3'd1, 3'd2, 3'd0);
        setin(1'b0, 1'b1, 3'd4, rd1_0 + rd2_0, 3'd1, 3'd2, 3'd0);
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 3'd4);
        push("alu_add_nb", 0, 8'h08);
        push("alu_add_b", 3, 8'h08);
        drain();
        setin(1'b0, 1'b0, 3'd6, 8'h00, 3'd1, 3'd1, 3'd0);
        setin(1'b0, 1'b1, 3'd6, rd1_0 - rd2_0, 3'd1, 3'd1, 3'd0);
        tick();
        setin(1'b0, 1'b0, 3'd0, 8'h00, 3'd6, 3'd6, 3'd6);
        push("alu_sub_r6", 0, 8'h00);
        push("alu_zero", 6, 8'h01);
        drain();

        // Random traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            setin(($urandom_range(15) == 0), 1'($urandom), 3'($urandom),
                  8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            push_model("rand");
            drain();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_regfile.md
# mips_regfile

Register file directly upstream of the 8-bit MIPS ALU. It supplies both ALU operands (`a` from `rd1`, `b` from `rd2`) and accepts the ALU result `s` (or another write-back value) as write data. Reads are combinational so the single-cycle datapath completes in one clock. Writes are synchronous. Register 0 is hardwired to zero.

## Interface
- `WIDTH`, 8: data width; matches the ALU operand width.
- `NREGS`, 8: number of registers; must be a power of two and ≥ 2.
- `AW`, $clog2(NREGS): address width; derived, never overridden.
- `BYPASS`, 0: 1 enables write-to-read forwarding on `rd1`, `rd2` and `dbg_data`.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ra1` input AW: read address, port 1 (ALU `a`).
- `ra2` input AW: read address, port 2 (ALU `b`).
- `rd1` output WIDTH: read data, port 1.
- `rd2` output WIDTH: read data, port 2.
- `we` input 1: write enable.
- `wa` input AW: write address.
- `wd` input WIDTH: write data (ALU `s` or load data).
- `dbg_addr` input AW: debug/observation read address.
- `dbg_data` output WIDTH: debug read data; same rules as `rd1` and `rd2`.

## Operation
- Storage is `NREGS` × `WIDTH` bits. Entry 0 is not stored and always reads 0.
- Reset:
  - When `rst`=1 at a rising edge, all stored registers become 0.
  - `rst` has priority over `we`; a write in the reset cycle is dropped.
- Write:
  - When `rst`=0, `we`=1 and `wa`≠0 at a rising edge, reg[`wa`] ← `wd`.
  - `wa`=0 is a legal no-op.
  - `we`=0 leaves all registers unchanged.
- Read, `BYPASS`=0:
  - `rdN` = (`raN`==0) ? 0 : reg[`raN`].
  - Purely combinational from the current register contents.
- Read, `BYPASS`=1:
  - If `we`=1, `rst`=0, `wa`≠0 and `wa`==`raN`, then `rdN` = `wd`.
  - Otherwise the `BYPASS`=0 rule applies.
  - Forwarding applies to `rd1`, `rd2` and `dbg_data` independently.
- Simultaneous events:
  - `ra1`==`ra2` returns identical data on both ports.
  - Read and write to the same address in one cycle: `BYPASS`=0 returns the old value (single-cycle semantics); `BYPASS`=1 returns `wd`.
- All addresses are in range by construction (`NREGS` = 2^`AW`), so there is no out-of-range case.

## Timing
- Write latency is 1 clock. Data written at edge k is visible on reads from just after edge k.
- Read latency is 0 clocks, combinational from the address inputs. The path `ra` → `rd` → ALU → `wd` must close in one cycle.
- Reset:
  - Takes effect at the first rising edge with `rst`=1.
  - During the reset cycle, read outputs still show pre-reset contents; bypass is suppressed.
  - From the following cycle, every read returns 0.
- Reset asserted mid-program discards every register. There is no partial state.
- Output reset values: `rd1`, `rd2` and `dbg_data` are 0 for every address after reset, until a write.
- No handshake. `we` is sampled every edge, and the write path never stalls.

## Structure
- Shared package `mips_pkg`:
  - `DATA_W`=8 and `NREGS`=8 (shared with ALU and datapath).
  - `REG_ZERO`=0.
  - Typedefs `data_t` (logic [DATA_W-1:0]) and `regaddr_t`.
- Sub-module `mips_reg_cell`:
  - One `WIDTH`-bit register with synchronous reset and write enable.
  - Generated for indices 1..`NREGS`-1.
- The top level holds the write-address decode, the three read muxes and the optional bypass compare.

## Test plan
- Reset then read all: `rst`=1 for 1 cycle, sweep `ra1`, `ra2` and `dbg_addr` over 0..7 → all reads 0.
- Write/readback: write 0xA5 to r3 and 0x3C to r7 → `rd1`(ra1=3)=0xA5, `rd2`(ra2=7)=0x3C, `dbg_data`(3)=0xA5.
- r0 immutable: `we`=1, `wa`=0, `wd`=0xFF → `rd1`(0)=0x00 in that cycle and all following cycles.
- Same-cycle read/write: r5=0x11, then `we`=1, `wa`=5, `wd`=0x22 with `ra1`=5:
  - `BYPASS`=0: `rd1`=0x11 before the edge, 0x22 after.
  - `BYPASS`=1: `rd1`=0x22 immediately.
- Reset priority mid-operation: r2=0x55, then `rst`=1 with `we`=1, `wa`=2, `wd`=0x77 → next cycle `rd1`(2)=0x00, not 0x77; bypass is not applied during the reset cycle.
- ALU loop: r1=0x05, r2=0x03; route ALU add of `rd1`+`rd2` back as `wd` to r4 → r4=0x08. Then ALU subtract r1-r1 to r6 → r6=0x00 and ALU `zero`=1.
